multicycle_ctrl_fsm: RTL

Main control FSM for the multi-cycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the shared ALU's source muxes and ALUop into the existing ALU decoder, plus PC, IR, memory and register-file enables. Single shared ALU and single unified memory port, with a ready handshake on memory.

---
 rtl/multicycle_ctrl_fsm.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences each instruction through fetch, decode, execute, memory and writeback.
// It drives the shared ALU source muxes and ALUop, and the PC, IR, memory and
// register-file enables. Memory is a single unified port with a ready handshake.
//
// Ports:
//   clk, reset          core clock; synchronous active-high reset
//   op, funct7b5, zero  opcode, instruction bit 30 and ALU zero flag
//   mem_ready           memory completes the current access this cycle
//   pc_write, ir_write, mem_write, reg_write   state enables (held low in reset)
//   adr_src, result_src, alu_src_a, alu_src_b  datapath mux selects
//   alu_op, alu_f7b5    controls sent to the ALU decoder
//   imm_src             immediate format select
//   illegal_op          unsupported opcode seen in DECODE
//   state_dbg           current state encoding
//   instret             retired-instruction count
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 alu_f7b5,
  output logic                 reg_write,
  output logic [1:0]           imm_src,
  output logic                 illegal_op,
  output logic [3:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 retire;
  logic                 pc_we, ir_we, mem_we, reg_we;

  // Next state and retirement. Codes 11-15 fall to the default and return to FETCH.
  always_comb begin
    state_d = StFetch;
    retire  = 1'b0;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecuteR;
          OpItype:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBeq;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        state_d = mem_ready ? StFetch : StMemWrite;
        retire  = mem_ready;
      end
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      // JAL retires through ALUWB, so it is not counted here.
      StJal:      state_d = StAluWb;
      StBeq: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we      = mem_ready;
        pc_we      = mem_ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLoad, OpStore, OpRtype, OpItype, OpJal, OpBranch: illegal_op = 1'b0;
          default:                                            illegal_op = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
      end
      StMemWrite: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecuteI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb:    reg_we = 1'b1;
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_we     = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_we     = zero;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset so nothing commits while state is unknown.
  assign pc_write  = pc_we & ~reset;
  assign ir_write  = ir_we & ~reset;
  assign mem_write = mem_we & ~reset;
  assign reg_write = reg_we & ~reset;

  // Masking with op[5] keeps immediate bit 10 of I-type ops from selecting SUB.
  assign alu_f7b5 = funct7b5 & op[5];

  always_comb begin
    case (op)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign state_dbg = state_q;
  assign instret   = instret_q;

endmodule
